// File: rtl/core_hazard_ctrl.sv
// Hazard controller beside ID: register scoreboard, mul/div sequencer and redirect flush stretcher.
// Optional saturating stall counter on port stall_cycles when HAZARD_STATS_EN is defined.
module core_hazard_ctrl #(
    parameter int MULDIV_LATENCY = 8,
    parameter int FLUSH_CYCLES   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_B_is_reg,
    input  logic        id_write_enable,
    input  logic [4:0]  id_W_regnum,
    input  logic        id_is_load,
    input  logic        id_is_muldiv,
    input  logic        ex_redirect,
    input  logic        wb_write_enable,
    input  logic [4:0]  wb_W_regnum,
    output logic        stall,
    output logic        flush,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic        muldiv_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {IDLE, BUSY} md_state_e;

    md_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [31:0] pending_q, pending_d;
    logic        hz_rs, hz_rt, hz_md, hz_waw, issue;

    always_comb begin
        flush  = ex_redirect | (fcnt_q != 3'd0);
        // A writeback landing this cycle is forwarded by ID, so it does not block a reader.
        hz_rs  = pending_q[id_rs] & ~(wb_write_enable & (wb_W_regnum == id_rs));
        hz_rt  = id_B_is_reg & pending_q[id_rt] & ~(wb_write_enable & (wb_W_regnum == id_rt));
        hz_md  = id_is_muldiv & (state_q == BUSY);
        hz_waw = id_write_enable & pending_q[id_W_regnum];
        stall  = id_valid & ~flush & (hz_rs | hz_rt | hz_md | hz_waw);
        issue  = id_valid & ~stall & ~flush;
    end

    always_comb begin
        pending_d = pending_q;
        if (wb_write_enable)
            pending_d[wb_W_regnum] = 1'b0;
        if (issue & id_write_enable & (id_is_load | id_is_muldiv) & (id_W_regnum != 5'd0))
            pending_d[id_W_regnum] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        muldiv_start = 1'b0;
        muldiv_done  = 1'b0;
        muldiv_busy  = (state_q == BUSY);
        case (state_q)
            IDLE: begin
                if (issue & id_is_muldiv) begin
                    muldiv_start = 1'b1;
                    cnt_d        = 8'(MULDIV_LATENCY - 1);
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    muldiv_done = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        if (ex_redirect)
            fcnt_d = 3'(FLUSH_CYCLES - 1);
        else if (fcnt_q != 3'd0)
            fcnt_d = fcnt_q - 3'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            fcnt_q    <= 3'd0;
            pending_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
            pending_q <= pending_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) stall_cycles_q <= 32'd0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl with MULDIV_LATENCY=8, FLUSH_CYCLES=3.
module tb_core_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_B_is_reg, id_write_enable, id_is_load, id_is_muldiv;
    logic [4:0] id_rs, id_rt, id_W_regnum, wb_W_regnum;
    logic       ex_redirect, wb_write_enable;
    logic       stall, flush, muldiv_start, muldiv_busy, muldiv_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    core_hazard_ctrl #(.MULDIV_LATENCY(8), .FLUSH_CYCLES(3)) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_B_is_reg(id_B_is_reg),
        .id_write_enable(id_write_enable), .id_W_regnum(id_W_regnum),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
        .ex_redirect(ex_redirect), .wb_write_enable(wb_write_enable), .wb_W_regnum(wb_W_regnum),
        .stall(stall), .flush(flush), .muldiv_start(muldiv_start),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        id_valid = 0; id_rs = 0; id_rt = 0; id_B_is_reg = 0; id_write_enable = 0;
        id_W_regnum = 0; id_is_load = 0; id_is_muldiv = 0; ex_redirect = 0;
        wb_write_enable = 0; wb_W_regnum = 0;
    endtask

    // Advance one edge; inputs change 1 time unit after it, checks follow #1 later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd);
        clr_in();
        id_valid = 1; id_is_load = 1; id_write_enable = 1; id_W_regnum = rd;
        #1 chk("load_issue_nostall", stall, 0);
        cyc();
    endtask

    initial begin
        clr_in();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_busy", muldiv_busy, 0);
        chk("rst_done", muldiv_done, 0);
        chk("rst_start", muldiv_start, 0);
        cyc();

        // Load-use on r5
        issue_load(5'd5);
        clr_in(); id_valid = 1; id_rs = 5;
        #1 chk("lu_stall1", stall, 1);
        cyc();
        #1 chk("lu_stall2", stall, 1);
        cyc();
        wb_write_enable = 1; wb_W_regnum = 5;
        #1 chk("lu_wb_fwd", stall, 0);
        cyc();
        clr_in(); id_valid = 1; id_rs = 5;
        #1 chk("lu_cleared", stall, 0);
        cyc();

        // rt gating on r7
        issue_load(5'd7);
        clr_in(); id_valid = 1; id_rt = 7; id_B_is_reg = 0;
        #1 chk("rt_not_reg", stall, 0);
        id_B_is_reg = 1;
        #1 chk("rt_is_reg", stall, 1);
        cyc();

        // Redirect over an active stall: 3 flush cycles, scoreboard kept
        ex_redirect = 1;
        #1 chk("fl0_flush", flush, 1);
        chk("fl0_stall", stall, 0);
        cyc();
        ex_redirect = 0;
        #1 chk("fl1_flush", flush, 1);
        chk("fl1_stall", stall, 0);
        cyc();
        #1 chk("fl2_flush", flush, 1);
        chk("fl2_stall", stall, 0);
        cyc();
        #1 chk("fl3_flush", flush, 0);
        chk("fl3_pending_kept", stall, 1);
        wb_write_enable = 1; wb_W_regnum = 7;
        #1 chk("fl3_wb", stall, 0);
        cyc();

        // Register 0 is never pending
        issue_load(5'd0);
        clr_in(); id_valid = 1; id_rs = 0; id_rt = 0; id_B_is_reg = 1;
        #1 chk("r0_nostall", stall, 0);
        cyc();

        // WAW against an outstanding load on r9
        issue_load(5'd9);
        clr_in(); id_valid = 1; id_write_enable = 1; id_W_regnum = 9;
        #1 chk("waw_stall", stall, 1);
        cyc();
        clr_in(); wb_write_enable = 1; wb_W_regnum = 9;
        cyc();

        // Mul/div back-to-back: start at t, done at t+8, second start at t+9
        clr_in(); id_valid = 1; id_is_muldiv = 1; id_write_enable = 1; id_W_regnum = 10;
        #1 chk("md_t_start", muldiv_start, 1);
        chk("md_t_stall", stall, 0);
        chk("md_t_busy", muldiv_busy, 0);
        cyc();
        id_W_regnum = 11;
        for (int k = 1; k <= 8; k++) begin
            #1 chk($sformatf("md_t%0d_busy", k), muldiv_busy, 1);
            chk($sformatf("md_t%0d_stall", k), stall, 1);
            chk($sformatf("md_t%0d_start", k), muldiv_start, 0);
            chk($sformatf("md_t%0d_done", k), muldiv_done, (k == 8) ? 1 : 0);
            cyc();
        end
        #1 chk("md_t9_start", muldiv_start, 1);
        chk("md_t9_stall", stall, 0);
        chk("md_t9_busy", muldiv_busy, 0);
        cyc();
        clr_in();
        #1 chk("md2_busy", muldiv_busy, 1);
        cyc(); cyc();
        // Reset three cycles after the second start
        reset = 1;
        cyc();
        reset = 0;
        #1 chk("rb_busy", muldiv_busy, 0);
        chk("rb_done", muldiv_done, 0);
        id_valid = 1; id_rs = 10; id_rt = 11; id_B_is_reg = 1;
        #1 chk("rb_pending_clear", stall, 0);
`ifdef HAZARD_STATS_EN
        chk("rb_stall_cycles", stall_cycles, 0);
`endif
        cyc();
        clr_in();
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("rb_nodone%0d", k), muldiv_done, 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
